// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/bubble on operand hazards against the E and M stages.
// Define HAZ_MD_EN to add the mult/div busy counter and its HI/LO interlock.
module hazard_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       EXC_flush,
    input  logic [1:0] Res_D,
    input  logic [4:0] A1_D,
    input  logic [4:0] A2_D,
    input  logic [4:0] A3_D,
    input  logic [1:0] Tuse_rs_D,
    input  logic [1:0] Tuse_rt_D,
    input  logic       md_start_D,
    input  logic       md_is_div_D,
    input  logic       md_use_D,
    output logic       stall,
    output logic       clr_E,
    output logic       md_busy
);

    typedef enum logic [1:0] {
        RES_NW  = 2'b00,
        RES_ALU = 2'b01,
        RES_DM  = 2'b10,
        RES_PC  = 2'b11
    } res_t;

    localparam logic [1:0] TUSE_NONE = 2'b11;

    res_t       res_e, res_m;
    logic [4:0] a3_e, a3_m;
    logic [1:0] tnew_e, tnew_m;
    logic       stall_rs, stall_rt, stall_md;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        tnew_e = 2'd0;
        tnew_m = 2'd0;
        case (res_e)
            RES_ALU: tnew_e = 2'd1;
            RES_DM:  tnew_e = 2'd2;
            default: tnew_e = 2'd0;
        endcase
        if (res_m == RES_DM)
            tnew_m = 2'd1;
    end

    // A nonzero source equal to a3_x already excludes writes to $zero.
    assign stall_rs = (A1_D != 5'd0) && (Tuse_rs_D != TUSE_NONE) &&
                      (((A1_D == a3_e) && (res_e != RES_NW) && (tnew_e > Tuse_rs_D)) ||
                       ((A1_D == a3_m) && (res_m != RES_NW) && (tnew_m > Tuse_rs_D)));

    assign stall_rt = (A2_D != 5'd0) && (Tuse_rt_D != TUSE_NONE) &&
                      (((A2_D == a3_e) && (res_e != RES_NW) && (tnew_e > Tuse_rt_D)) ||
                       ((A2_D == a3_m) && (res_m != RES_NW) && (tnew_m > Tuse_rt_D)));

    assign stall = stall_rs | stall_rt | stall_md;
    assign clr_E = stall;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_e <= RES_NW;
            a3_e  <= 5'd0;
            res_m <= RES_NW;
            a3_m  <= 5'd0;
        end else if (EXC_flush) begin
            res_e <= RES_NW;
            a3_e  <= 5'd0;
            res_m <= RES_NW;
            a3_m  <= 5'd0;
        end else begin
            res_m <= res_e;
            a3_m  <= a3_e;
            if (stall) begin
                res_e <= RES_NW;
                a3_e  <= 5'd0;
            end else begin
                res_e <= res_t'(Res_D);
                a3_e  <= A3_D;
            end
        end
    end

`ifdef HAZ_MD_EN
    logic [3:0] md_cnt;

    assign md_busy  = (md_cnt != 4'd0);
    assign stall_md = md_busy & (md_use_D | md_start_D);

    // A start while busy is held by stall_md, so a new op never overlaps the running one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            md_cnt <= 4'd0;
        else if (md_start_D && !stall && !EXC_flush)
            md_cnt <= md_is_div_D ? 4'd10 : 4'd5;
        else if (md_cnt != 4'd0)
            md_cnt <= md_cnt - 4'd1;
    end
`else
    logic unused_md;

    assign md_busy   = 1'b0;
    assign stall_md  = 1'b0;
    assign unused_md = ^{md_start_D, md_is_div_D, md_use_D};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomised and directed bench for hazard_ctrl against a latency-based reference model.
// Define HAZ_MD_EN for both bench and design to exercise the mult/div interlock.
module tb_hazard_ctrl;

`ifdef HAZ_MD_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       EXC_flush;
    logic [1:0] Res_D;
    logic [4:0] A1_D, A2_D, A3_D;
    logic [1:0] Tuse_rs_D, Tuse_rt_D;
    logic       md_start_D, md_is_div_D, md_use_D;
    logic       stall, clr_E, md_busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: what sits in E and M, plus the cycle the mult/div finishes.
    logic [1:0] m_res_e = 2'd0, m_res_m = 2'd0;
    logic [4:0] m_a3_e = 5'd0, m_a3_m = 5'd0;
    int         cyc    = 0;
    int         md_end = -1000;

    hazard_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .EXC_flush   (EXC_flush),
        .Res_D       (Res_D),
        .A1_D        (A1_D),
        .A2_D        (A2_D),
        .A3_D        (A3_D),
        .Tuse_rs_D   (Tuse_rs_D),
        .Tuse_rt_D   (Tuse_rt_D),
        .md_start_D  (md_start_D),
        .md_is_div_D (md_is_div_D),
        .md_use_D    (md_use_D),
        .stall       (stall),
        .clr_E       (clr_E),
        .md_busy     (md_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Cycles after E until a result class is available: ALU 1, DM 2, otherwise 0.
    function automatic int latency(input logic [1:0] r);
        if (r == 2'b01) return 1;
        if (r == 2'b10) return 2;
        return 0;
    endfunction

    function automatic bit must_wait(input logic [4:0] a, input logic [1:0] tuse);
        if (a == 5'd0 || tuse == 2'b11) return 1'b0;
        if (m_res_e != 2'd0 && m_a3_e == a && latency(m_res_e) > int'(tuse)) return 1'b1;
        if (m_res_m != 2'd0 && m_a3_m == a && latency(m_res_m) - 1 > int'(tuse)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_res_e = 2'd0;
        m_res_m = 2'd0;
        m_a3_e  = 5'd0;
        m_a3_m  = 5'd0;
        md_end  = -1000;
    endtask

    // One clock cycle: drive D at the falling edge, compare, then advance the model over the next rising edge.
    task automatic step(input logic fl, input logic [1:0] res, input logic [4:0] a1, a2, a3,
                        input logic [1:0] tr, tt, input logic st, dv, us, output logic obs);
        logic exp_busy, exp_stall;
        @(negedge clk);
        EXC_flush   = fl;
        Res_D       = res;
        A1_D        = a1;
        A2_D        = a2;
        A3_D        = a3;
        Tuse_rs_D   = tr;
        Tuse_rt_D   = tt;
        md_start_D  = st;
        md_is_div_D = dv;
        md_use_D    = us;
        #1;
        exp_busy  = MD_EN && (cyc <= md_end);
        exp_stall = must_wait(a1, tr) || must_wait(a2, tt) || (exp_busy && (us || st));

        n_checks++;
        if ({dut.res_e, dut.a3_e, dut.res_m, dut.a3_m} !== {m_res_e, m_a3_e, m_res_m, m_a3_m}) begin
            n_fail++;
            $display("FAIL stage_regs cyc=%0d: got E=%0d/%0d M=%0d/%0d expected E=%0d/%0d M=%0d/%0d",
                     cyc, dut.res_e, dut.a3_e, dut.res_m, dut.a3_m, m_res_e, m_a3_e, m_res_m, m_a3_m);
        end
        n_checks++;
        if (stall !== exp_stall) begin
            n_fail++;
            $display("FAIL stall cyc=%0d: got %0b expected %0b", cyc, stall, exp_stall);
        end
        n_checks++;
        if (clr_E !== exp_stall) begin
            n_fail++;
            $display("FAIL clr_E cyc=%0d: got %0b expected %0b", cyc, clr_E, exp_stall);
        end
        n_checks++;
        if (md_busy !== exp_busy) begin
            n_fail++;
            $display("FAIL md_busy cyc=%0d: got %0b expected %0b", cyc, md_busy, exp_busy);
        end
`ifdef HAZ_MD_EN
        n_checks++;
        if (int'(dut.md_cnt) !== (exp_busy ? md_end - cyc + 1 : 0)) begin
            n_fail++;
            $display("FAIL md_cnt cyc=%0d: got %0d expected %0d", cyc, dut.md_cnt,
                     exp_busy ? md_end - cyc + 1 : 0);
        end
`endif
        obs = stall;

        if (MD_EN && st && !exp_stall && !fl)
            md_end = cyc + (dv ? 10 : 5);
        if (fl) begin
            m_res_e = 2'd0; m_a3_e = 5'd0;
            m_res_m = 2'd0; m_a3_m = 5'd0;
        end else begin
            m_res_m = m_res_e;
            m_a3_m  = m_a3_e;
            m_res_e = exp_stall ? 2'd0 : res;
            m_a3_e  = exp_stall ? 5'd0 : a3;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        logic obs;
        for (int i = 0; i < n; i++)
            step(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 2'b11, 2'b11, 1'b0, 1'b0, 1'b0, obs);
    endtask

    task automatic test_reset();
        logic obs;
        #1;
        n_checks++;
        if ({stall, clr_E, md_busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 000", {stall, clr_E, md_busy});
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        // Start a mult, put DM $3 in E, then reset asynchronously once md_cnt has reached 4.
        step(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 2'b11, 2'b11, 1'b1, 1'b0, 1'b0, obs);
        step(1'b0, 2'b10, 5'd0, 5'd0, 5'd3, 2'b11, 2'b11, 1'b0, 1'b0, 1'b0, obs);
        step(1'b0, 2'b00, 5'd3, 5'd0, 5'd0, 2'b00, 2'b11, 1'b0, 1'b0, 1'b1, obs);
        n_checks++;
        if (obs !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_stall: got %0b expected 1", obs);
        end
        #1 reset = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if ({stall, clr_E, md_busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL async_reset_outputs: got %b expected 000", {stall, clr_E, md_busy});
        end
`ifdef HAZ_MD_EN
        n_checks++;
        if (dut.md_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL async_reset_md_cnt: got %0d expected 0", dut.md_cnt);
        end
`endif
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_load_use();
        logic obs;
        idle(2);
        step(1'b0, 2'b10, 5'd0, 5'd0, 5'd3, 2'b11, 2'b11, 1'b0, 1'b0, 1'b0, obs);
        step(1'b0, 2'b00, 5'd3, 5'd0, 5'd0, 2'b01, 2'b11, 1'b0, 1'b0, 1'b0, obs);
        n_checks++;
        if (obs !== 1'b1) begin
            n_fail++;
            $display("FAIL load_use_stall: got %0b expected 1", obs);
        end
        step(1'b0, 2'b00, 5'd3, 5'd0, 5'd0, 2'b01, 2'b11, 1'b0, 1'b0, 1'b0, obs);
        n_checks++;
        if (obs !== 1'b0 || dut.res_m !== 2'b10) begin
            n_fail++;
            $display("FAIL load_use_release: got stall=%0b ResM=%0d expected stall=0 ResM=2", obs, dut.res_m);
        end
    endtask

    task automatic test_alu_forward();
        logic obs;
        idle(2);
        step(1'b0, 2'b01, 5'd0, 5'd0, 5'd5, 2'b11, 2'b11, 1'b0, 1'b0, 1'b0, obs);
        step(1'b0, 2'b00, 5'd0, 5'd5, 5'd0, 2'b11, 2'b01, 1'b0, 1'b0, 1'b0, obs);
        n_checks++;
        if (obs !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_forward: got %0b expected 0", obs);
        end
    endtask

    task automatic test_branch_after_alu();
        logic obs;
        int   stalls = 0;
        idle(2);
        step(1'b0, 2'b01, 5'd0, 5'd0, 5'd5, 2'b11, 2'b11, 1'b0, 1'b0, 1'b0, obs);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 2'b00, 5'd5, 5'd0, 5'd0, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0, obs);
            if (obs) stalls++;
        end
        n_checks++;
        if (stalls != 1) begin
            n_fail++;
            $display("FAIL branch_after_alu: got %0d stall cycles expected 1", stalls);
        end
    endtask

    task automatic test_zero_reg();
        logic obs;
        idle(2);
        step(1'b0, 2'b10, 5'd0, 5'd0, 5'd0, 2'b11, 2'b11, 1'b0, 1'b0, 1'b0, obs);
        step(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, obs);
        n_checks++;
        if (obs !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_reg: got %0b expected 0", obs);
        end
    endtask

    task automatic test_mult_div();
        logic obs;
        int   busy_cycles = 0;
        int   stalls = 0;
        idle(12);
        step(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 2'b11, 2'b11, 1'b1, 1'b1, 1'b0, obs);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 2'b11, 2'b11, 1'b0, 1'b0, 1'b0, obs);
            if (md_busy) busy_cycles++;
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 2'b11, 2'b11, 1'b0, 1'b0, 1'b1, obs);
            if (md_busy) busy_cycles++;
            if (!obs) break;
            stalls++;
        end
        n_checks++;
        if (busy_cycles != (MD_EN ? 10 : 0)) begin
            n_fail++;
            $display("FAIL div_busy_cycles: got %0d expected %0d", busy_cycles, MD_EN ? 10 : 0);
        end
        n_checks++;
        if (stalls != (MD_EN ? 7 : 0)) begin
            n_fail++;
            $display("FAIL mfhi_stall_cycles: got %0d expected %0d", stalls, MD_EN ? 7 : 0);
        end
    endtask

    task automatic test_back_to_back();
        logic obs;
        idle(12);
        step(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 2'b11, 2'b11, 1'b1, 1'b0, 1'b0, obs);
        idle(4);
        step(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 2'b11, 2'b11, 1'b1, 1'b0, 1'b0, obs);
        n_checks++;
        if (obs !== MD_EN) begin
            n_fail++;
            $display("FAIL start_at_cnt1_stall: got %0b expected %0b", obs, MD_EN);
        end
        if (MD_EN) step(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 2'b11, 2'b11, 1'b1, 1'b0, 1'b0, obs);
        idle(1);
        n_checks++;
        if (md_busy !== MD_EN) begin
            n_fail++;
            $display("FAIL delayed_load_busy: got %0b expected %0b", md_busy, MD_EN);
        end
    endtask

    task automatic test_flush();
        logic obs;
        idle(12);
        step(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 2'b11, 2'b11, 1'b1, 1'b0, 1'b0, obs);
        step(1'b0, 2'b10, 5'd0, 5'd0, 5'd7, 2'b11, 2'b11, 1'b0, 1'b0, 1'b0, obs);
        step(1'b1, 2'b01, 5'd7, 5'd0, 5'd9, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0, obs);
        n_checks++;
        if (obs !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_cycle_stall: got %0b expected 1", obs);
        end
        idle(1);
        n_checks++;
        if (dut.res_e !== 2'b00 || dut.res_m !== 2'b00) begin
            n_fail++;
            $display("FAIL flush_clears: got ResE=%0d ResM=%0d expected 0 0", dut.res_e, dut.res_m);
        end
`ifdef HAZ_MD_EN
        n_checks++;
        if (dut.md_cnt !== 4'd3) begin
            n_fail++;
            $display("FAIL flush_keeps_md_cnt: got %0d expected 3", dut.md_cnt);
        end
`endif
        idle(6);
        step(1'b1, 2'b00, 5'd0, 5'd0, 5'd0, 2'b11, 2'b11, 1'b1, 1'b1, 1'b0, obs);
        idle(1);
        n_checks++;
        if (md_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_blocks_load: got %0b expected 0", md_busy);
        end
    endtask

    task automatic test_random();
        logic obs;
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 19) == 0, 2'($urandom_range(0, 3)),
                 5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)),
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 $urandom_range(0, 7) == 0, 1'($urandom), $urandom_range(0, 5) == 0, obs);
    endtask

    initial begin
        reset       = 1'b1;
        EXC_flush   = 1'b0;
        Res_D       = 2'b00;
        A1_D        = 5'd0;
        A2_D        = 5'd0;
        A3_D        = 5'd0;
        Tuse_rs_D   = 2'b11;
        Tuse_rt_D   = 2'b11;
        md_start_D  = 1'b0;
        md_is_div_D = 1'b0;
        md_use_D    = 1'b0;
        test_reset();
        test_load_use();
        test_alu_forward();
        test_branch_after_alu();
        test_zero_reg();
        test_mult_div();
        test_back_to_back();
        test_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
